// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints a result word as uppercase hex + CR LF
// over an 8N1 UART line, one character per frame.
module uart_hex_tx #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data,
    input  logic [1:0]  size_sel,
    output logic        busy,
    output logic        done,
    output logic        UART_TXD
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST =
        CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        FINISH
    } state_t;

    // Which part of the line is being sent: digits, CR, LF.
    typedef enum logic [1:0] {
        TAIL_DIGITS,
        TAIL_CR,
        TAIL_LF
    } tail_t;

    state_t        state_q, state_d;
    tail_t         tail_q, tail_d;
    logic [63:0]   data_q, data_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    nib;
    logic [7:0]    hex_chr;
    logic [7:0]    next_chr;
    logic [3:0]    first_idx;
    logic          baud_end;

    assign nib      = data_q[{idx_q, 2'b00} +: 4];
    assign baud_end = (baud_q == BAUD_LAST);

    // Nibble to uppercase ASCII hex digit.
    always_comb begin
        hex_chr = 8'h30;
        unique case (1'b1)
            (nib <  4'd10): hex_chr = 8'h30 + {4'h0, nib};
            (nib >= 4'd10): hex_chr = 8'h37 + {4'h0, nib};
        endcase
    end

    // Character selected for the next frame.
    always_comb begin
        next_chr = 8'h0A;
        unique case (tail_q)
            TAIL_DIGITS: next_chr = hex_chr;
            TAIL_CR:     next_chr = 8'h0D;
            TAIL_LF:     next_chr = 8'h0A;
            default:     next_chr = 8'h0A;
        endcase
    end

    // Index of the most significant printed nibble.
    always_comb begin
        first_idx = 4'd15;
        unique case (size_sel)
            2'd0:    first_idx = 4'd3;
            2'd1:    first_idx = 4'd7;
            default: first_idx = 4'd15;
        endcase
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        data_d  = data_q;
        idx_d   = idx_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data;
                    idx_d   = first_idx;
                    tail_d  = TAIL_DIGITS;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d = next_chr;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START_BIT;
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA_BITS;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA_BITS: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = LOAD;
                    unique case (tail_q)
                        TAIL_DIGITS: begin
                            if (idx_q == 4'd0) begin
                                tail_d = TAIL_CR;
                            end else begin
                                idx_d = idx_q - 4'd1;
                            end
                        end
                        TAIL_CR: tail_d = TAIL_LF;
                        default: state_d = FINISH;
                    endcase
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        txd_d = 1'b1;
        unique case (state_d)
            START_BIT: txd_d = 1'b0;
            DATA_BITS: txd_d = shreg_d[0];
            default:   txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE) && (state_d != FINISH);
        done_d = (state_d == FINISH);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tail_q  <= TAIL_DIGITS;
            data_q  <= '0;
            idx_q   <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign UART_TXD = txd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
